// File: rtl/aes_inv_key_sched.sv
// Sequential AES key schedule walked backwards: round keys NR..0 over valid/ready.
// Define AES_INVKEY_EQV_EN to pass rounds 1..NR-1 through InvMixColumns.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] t;
    logic [7:0] inv;

    // multiplicative inverse as a^254, then the affine map
    always_comb begin
        t = a_i;
        for (int k = 0; k < 6; k++) t = gmul(gmul(t, t), a_i);
        inv = gmul(t, t);
        s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_inv_key_sched #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [32*NK-1:0]  key,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_idx,
    output logic              busy
);
    localparam int TOTAL = 4 * (NR + 1);
    localparam int LW = 6;

    typedef enum logic [1:0] {IDLE, FWD, REV} state_t;

    state_t       state_q;
    logic [31:0]  win_q [NK];
    logic [LW-1:0] lo_q;
    logic [3:0]   r_q;
    logic         rk_valid_q;
    logic [127:0] rk_data_q;
    logic [3:0]   rk_idx_q;
    logic         busy_q;

    function automatic logic [7:0] rcon(int n);
        case (n)
            1: return 8'h01;
            2: return 8'h02;
            3: return 8'h04;
            4: return 8'h08;
            5: return 8'h10;
            6: return 8'h20;
            7: return 8'h40;
            8: return 8'h80;
            9: return 8'h1b;
            10: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef AES_INVKEY_EQV_EN
    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(logic [127:0] d);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = d[127-32*c -: 8];
            a1 = d[119-32*c -: 8];
            a2 = d[111-32*c -: 8];
            a3 = d[103-32*c -: 8];
            o[127-32*c -: 8] = gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09);
            o[119-32*c -: 8] = gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d);
            o[111-32*c -: 8] = gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b);
            o[103-32*c -: 8] = gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e);
        end
        return o;
    endfunction
`endif

    logic          rev;
    logic [LW-1:0] tidx;
    int            ti;
    logic          rot;
    logic [31:0]   tin;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   temp;
    logic [31:0]   fwd_w;
    logic [31:0]   rev_w;

    // FWD derives w[lo+NK]; REV rebuilds w[lo-1] from w[lo+NK-1], w[lo+NK-2]
    assign rev = (state_q == REV);
    assign tidx = rev ? lo_q + LW'(NK - 1) : lo_q + LW'(NK);
    assign tin = rev ? win_q[NK-2] : win_q[NK-1];
    assign ti = int'(tidx);
    assign rot = (ti % NK) == 0;
    assign sub_in = rot ? {tin[23:0], tin[31:24]} : tin;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a_i(sub_in[8*g+7:8*g]), .s_o(sub_out[8*g+7:8*g]));
    end

    always_comb begin
        temp = tin;
        if (rot) temp = sub_out ^ {rcon(ti / NK), 24'h0};
        else if (NK == 8 && ti % NK == 4) temp = sub_out;
    end

    assign fwd_w = win_q[0] ^ temp;
    assign rev_w = win_q[NK-1] ^ temp;

    logic          hs;
    logic [3:0]    r_eff;
    logic [LW-1:0] base;
    logic          can_emit;
    logic [LW-1:0] off;
    logic [127:0]  emit_data;
    logic [127:0]  out_data;

    always_comb begin
        hs = rk_valid_q && rk_ready;
        r_eff = hs ? r_q - 4'd1 : r_q;
        base = {r_eff, 2'b00};
        can_emit = base >= lo_q;
        off = base - lo_q;
        emit_data = '0;
        for (int k = 0; k <= NK - 4; k++)
            if (int'(off) == k)
                emit_data = {win_q[k], win_q[k+1], win_q[k+2], win_q[k+3]};
        out_data = emit_data;
`ifdef AES_INVKEY_EQV_EN
        if (r_eff != 4'd0 && r_eff != 4'(NR)) out_data = inv_mix(emit_data);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int k = 0; k < NK; k++) win_q[k] <= '0;
            lo_q <= '0;
            r_q <= '0;
            rk_valid_q <= 1'b0;
            rk_data_q <= '0;
            rk_idx_q <= '0;
            busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    for (int k = 0; k < NK; k++) win_q[k] <= key[32*(NK-k)-1 -: 32];
                    lo_q <= '0;
                    busy_q <= 1'b1;
                    state_q <= FWD;
                end
                FWD: begin
                    for (int k = 0; k < NK - 1; k++) win_q[k] <= win_q[k+1];
                    win_q[NK-1] <= fwd_w;
                    lo_q <= lo_q + LW'(1);
                    if (lo_q == LW'(TOTAL - NK - 1)) begin
                        r_q <= 4'(NR);
                        state_q <= REV;
                    end
                end
                REV: begin
                    if (rk_valid_q && !rk_ready) begin
                        rk_valid_q <= 1'b1;
                    end else if (hs && r_q == 4'd0) begin
                        rk_valid_q <= 1'b0;
                        busy_q <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        r_q <= r_eff;
                        if (can_emit) begin
                            rk_valid_q <= 1'b1;
                            rk_data_q <= out_data;
                            rk_idx_q <= r_eff;
                        end else begin
                            rk_valid_q <= 1'b0;
                            for (int k = NK - 1; k > 0; k--) win_q[k] <= win_q[k-1];
                            win_q[0] <= rev_w;
                            lo_q <= lo_q - LW'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_valid = rk_valid_q;
    assign rk_data = rk_data_q;
    assign rk_idx = rk_idx_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Bench for aes_inv_key_sched: NK=4/6/8 instances against a forward-expansion model.
// Honors AES_INVKEY_EQV_EN in the expected round keys.
module tb_aes_inv_key_sched;
    logic clk = 1'b0;
    logic rst;
    logic start [3];
    logic [255:0] key [3];
    logic rk_ready [3];
    logic rk_valid [3];
    logic [127:0] rk_data [3];
    logic [3:0] rk_idx [3];
    logic busy [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_inv_key_sched #(.NK(4), .NR(10)) u4 (
        .clk(clk), .rst(rst), .start(start[0]), .key(key[0][127:0]),
        .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]), .rk_data(rk_data[0]),
        .rk_idx(rk_idx[0]), .busy(busy[0]));
    aes_inv_key_sched #(.NK(6), .NR(12)) u6 (
        .clk(clk), .rst(rst), .start(start[1]), .key(key[1][191:0]),
        .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]), .rk_data(rk_data[1]),
        .rk_idx(rk_idx[1]), .busy(busy[1]));
    aes_inv_key_sched #(.NK(8), .NR(14)) u8 (
        .clk(clk), .rst(rst), .start(start[2]), .key(key[2]),
        .rk_valid(rk_valid[2]), .rk_ready(rk_ready[2]), .rk_data(rk_data[2]),
        .rk_idx(rk_idx[2]), .busy(busy[2]));

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] sb(logic [7:0] b);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    function automatic logic [7:0] gm(logic [7:0] a, logic [3:0] c);
        logic [7:0] r;
        logic [7:0] x;
        r = '0;
        x = a;
        for (int k = 0; k < 4; k++) begin
            if (c[k]) r ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [127:0] imc(logic [127:0] d);
        logic [7:0] a [4];
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = d[127 - 32*c - 8*i -: 8];
            for (int i = 0; i < 4; i++)
                o[127 - 32*c - 8*i -: 8] = gm(a[i], 4'he) ^ gm(a[(i+1)%4], 4'hb)
                    ^ gm(a[(i+2)%4], 4'hd) ^ gm(a[(i+3)%4], 4'h9);
        end
        return o;
    endfunction

    logic [127:0] mrk [15];

    task automatic expand(input int nk, input int nr, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0] rc [11];
        rc = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < nk; i++) w[i] = k[32*(nk-i)-1 -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
`ifdef AES_INVKEY_EQV_EN
            if (r != 0 && r != nr) mrk[r] = imc(mrk[r]);
`endif
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        int idx;
        logic [127:0] data;
    } exp_t;

    task automatic run_seq(input int n, input logic [255:0] k, input int stall_idx,
                           input int poke_idx, input int rst_idx,
                           output logic [127:0] first_d, output logic [127:0] mid_d,
                           output logic [127:0] last_d, output int hs);
        exp_t q [$];
        exp_t e;
        int nk;
        int nr;
        int cyc;
        bit was_reset;
        nk = 4 + 2*n;
        nr = 10 + 2*n;
        expand(nk, nr, k);
        for (int r = nr; r >= 0; r--) q.push_back('{r, mrk[r]});
        first_d = '0;
        mid_d = '0;
        last_d = '0;
        hs = 0;
        cyc = 0;
        was_reset = 0;
        @(negedge clk);
        key[n] = k;
        start[n] = 1'b1;
        @(negedge clk);
        start[n] = 1'b0;
        chk("busy_after_start", busy[n], 1'b1);
        while (q.size() > 0 && cyc < 3000 && !was_reset) begin
            @(negedge clk);
            cyc++;
            start[n] = 1'b0;
            rk_ready[n] = 1'b1;
            if (rk_valid[n]) begin
                e = q[0];
                chk("rk_idx", rk_idx[n], 128'(e.idx));
                chk("rk_data", rk_data[n], e.data);
                if (e.idx == rst_idx) begin
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    chk("rst_valid", rk_valid[n], 1'b0);
                    chk("rst_busy", busy[n], 1'b0);
                    chk("rst_idx", rk_idx[n], 0);
                    chk("rst_data", rk_data[n], 0);
                    rst = 1'b0;
                    was_reset = 1;
                end else begin
                    if (e.idx == stall_idx) begin
                        rk_ready[n] = 1'b0;
                        repeat (5) begin
                            @(negedge clk);
                            chk("stall_valid", rk_valid[n], 1'b1);
                            chk("stall_data", rk_data[n], e.data);
                            chk("stall_idx", rk_idx[n], 128'(e.idx));
                        end
                        rk_ready[n] = 1'b1;
                    end
                    if (hs == 0) first_d = rk_data[n];
                    if (e.idx == 1) mid_d = rk_data[n];
                    if (e.idx == 0) last_d = rk_data[n];
                    void'(q.pop_front());
                    hs++;
                    if (e.idx == poke_idx) begin
                        key[n] = ~k;
                        start[n] = 1'b1;
                    end
                end
            end
        end
        start[n] = 1'b0;
        if (q.size() > 0 && !was_reset) begin
            checks++;
            errors++;
            $display("FAIL timeout inst %0d: %0d keys outstanding", n, q.size());
        end
        if (!was_reset) begin
            @(negedge clk);
            rk_ready[n] = 1'b0;
            chk("done_busy", busy[n], 1'b0);
            chk("done_valid", rk_valid[n], 1'b0);
        end
        rk_ready[n] = 1'b0;
    endtask

    typedef struct {
        int n;
        logic [255:0] k;
        logic [127:0] first;
        logic [127:0] last;
        bit has_mid;
        logic [127:0] mid;
    } vec_t;

    vec_t tbl [3];
    logic [127:0] f_d;
    logic [127:0] m_d;
    logic [127:0] l_d;
    int nhs;

    initial begin
        tbl[0] = '{0, 256'h000102030405060708090a0b0c0d0e0f,
                   128'h13111d7fe3944a17f307a78b4d2b30c5,
                   128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h0};
        tbl[1] = '{1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617,
                   128'ha4970a331a78dc09c418c271e3a41d5d,
                   128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h0};
        tbl[2] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   128'h24fc79ccbf0979e9371ac23c6d68de36,
                   128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                   128'h101112131415161718191a1b1c1d1e1f};
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            key[i] = '0;
            rk_ready[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", rk_valid[i], 1'b0);
            chk("reset_busy", busy[i], 1'b0);
            chk("reset_idx", rk_idx[i], 0);
            chk("reset_data", rk_data[i], 0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            run_seq(tbl[i].n, tbl[i].k, -1, -1, -1, f_d, m_d, l_d, nhs);
            chk("first_key", f_d, tbl[i].first);
            chk("last_key", l_d, tbl[i].last);
            chk("handshakes", 128'(nhs), 128'(11 + 2*tbl[i].n));
`ifndef AES_INVKEY_EQV_EN
            if (tbl[i].has_mid) chk("idx1_key", m_d, tbl[i].mid);
`endif
        end

        run_seq(0, tbl[0].k, 10, 7, -1, f_d, m_d, l_d, nhs);
        chk("bp_first", f_d, tbl[0].first);
        chk("bp_handshakes", 128'(nhs), 11);

        run_seq(0, tbl[0].k, -1, -1, 5, f_d, m_d, l_d, nhs);
        run_seq(0, tbl[0].k, -1, -1, -1, f_d, m_d, l_d, nhs);
        chk("restart_first", f_d, tbl[0].first);
        chk("restart_handshakes", 128'(nhs), 11);

        for (int i = 0; i < 3; i++)
            run_seq(i, {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom},
                    -1, -1, -1, f_d, m_d, l_d, nhs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
